// File: rtl/branch_outcome_checker_if.sv
// branch_outcome_checker_if: prediction/resolution bus between pipeline (master) and checker (slave).
// Statistics signals exist only when BRCHK_STATS_EN is defined.
interface branch_outcome_checker_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              pred_valid;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_alt_pc;
    logic              res_valid;
    logic              res_taken;
    logic              PreRight;
    logic              PreWrong;
    logic              flush;
    logic [ADDR_W-1:0] redirect_pc;
    logic              full;
    logic              empty;
`ifdef BRCHK_STATS_EN
    logic [CNT_W-1:0]  n_branch;
    logic [CNT_W-1:0]  n_miss;
    modport master (output stall, pred_valid, pred_taken, pred_alt_pc, res_valid, res_taken,
                    input PreRight, PreWrong, flush, redirect_pc, full, empty, n_branch, n_miss);
    modport slave  (input stall, pred_valid, pred_taken, pred_alt_pc, res_valid, res_taken,
                    output PreRight, PreWrong, flush, redirect_pc, full, empty, n_branch, n_miss);
`else
    modport master (output stall, pred_valid, pred_taken, pred_alt_pc, res_valid, res_taken,
                    input PreRight, PreWrong, flush, redirect_pc, full, empty);
    modport slave  (input stall, pred_valid, pred_taken, pred_alt_pc, res_valid, res_taken,
                    output PreRight, PreWrong, flush, redirect_pc, full, empty);
`endif
endinterface

// File: rtl/branch_outcome_checker.sv
// branch_outcome_checker: in-order queue of branch predictions, checked against EX outcomes.
// Optional BRCHK_STATS_EN adds saturating resolved/mispredict counters.
module branch_outcome_checker #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    branch_outcome_checker_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0]     r_rd, r_wr;
    logic [PW:0]       r_cnt;
    logic              r_tk [DEPTH];
    logic [ADDR_W-1:0] r_pc [DEPTH];
    logic              r_right, r_wrong;
    logic [ADDR_W-1:0] r_redir;
    logic              w_full, w_empty, w_pop, w_push, w_miss;
    assign w_full  = r_cnt == (PW+1)'(DEPTH);
    assign w_empty = r_cnt == '0;
    assign w_pop   = bus.res_valid & ~bus.stall & ~w_empty;
    assign w_push  = bus.pred_valid & ~bus.stall & (~w_full | w_pop);
    assign w_miss  = w_pop & (r_tk[r_rd] != bus.res_taken);
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.PreRight    = r_right;
    assign bus.PreWrong    = r_wrong;
    assign bus.flush       = r_wrong;
    assign bus.redirect_pc = r_redir;
    // Entry storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tk[r_wr] <= bus.pred_taken;
            r_pc[r_wr] <= bus.pred_alt_pc;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_cnt   <= '0;
            r_right <= 1'b0;
            r_wrong <= 1'b0;
            r_redir <= '0;
        end else if (!bus.stall) begin
            r_right <= w_pop & ~w_miss;
            r_wrong <= w_miss;
            if (w_miss) r_redir <= r_pc[r_rd];
            // A mispredict squashes everything younger, including a same-cycle push.
            if (w_miss) begin
                r_rd  <= '0;
                r_wr  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) r_wr <= r_wr + 1'b1;
                if (w_pop) r_rd <= r_rd + 1'b1;
                r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
            end
        end
    end
`ifdef BRCHK_STATS_EN
    logic [CNT_W-1:0] r_nb, r_nm;
    assign bus.n_branch = r_nb;
    assign bus.n_miss   = r_nm;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nb <= '0;
            r_nm <= '0;
        end else begin
            if (w_pop && !(&r_nb)) r_nb <= r_nb + 1'b1;
            if (w_miss && !(&r_nm)) r_nm <= r_nm + 1'b1;
        end
    end
`endif
endmodule
